// File: rtl/mem_io_ctrl.sv
// Data-side memory and I/O controller for the single-cycle CPU: word RAM plus
// memory-mapped keyboard FIFO, cycle timer, LFSR random source and LED register.
module mem_io_ctrl #(
  parameter int          DATA_WORDS = 256,
  parameter int          KEY_DEPTH  = 8,
  parameter logic [31:0] LFSR_SEED  = 32'hACE12345
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  output logic [7:0]  leds
);

  localparam int AW = $clog2(DATA_WORDS);
  localparam int PW = $clog2(KEY_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [29:0] IO_BASE = 30'h3FFF_C000;  // word index of 0xFFFF_0000

  logic [31:0]   r_ram [DATA_WORDS];
  logic [7:0]    r_fifo [KEY_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [31:0]   r_timer;
  logic [31:0]   r_rand;
  logic [7:0]    r_leds;

  logic [29:0]   w_word;
  logic          w_ram_hit, w_stat_hit, w_data_hit, w_timer_hit, w_rand_hit, w_led_hit;
  logic [AW-1:0] w_ram_idx;
  logic          w_full, w_empty, w_pop, w_push, w_drop;
  logic [31:0]   w_cnt32;
  logic [3:0]    w_cnt_field;
  logic          w_rand_fb;
  logic          w_unused;

  assign w_unused    = ^addr[1:0];
  assign w_word      = addr[31:2];
  assign w_ram_hit   = (addr[31:AW+2] == '0);
  assign w_ram_idx   = addr[AW+1:2];
  assign w_stat_hit  = (w_word == IO_BASE);
  assign w_data_hit  = (w_word == IO_BASE + 30'd1);
  assign w_timer_hit = (w_word == IO_BASE + 30'd2);
  assign w_rand_hit  = (w_word == IO_BASE + 30'd3);
  assign w_led_hit   = (w_word == IO_BASE + 30'd4);

  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign w_full  = (r_count == CW'(KEY_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = memread & w_data_hit & ~w_empty;
  assign w_push  = key_valid & (~w_full | w_pop);
  assign w_drop  = key_valid & w_full & ~w_pop;

  assign w_cnt32     = 32'(r_count);
  assign w_cnt_field = (w_cnt32 > 32'd15) ? 4'hF : w_cnt32[3:0];
  assign w_rand_fb   = r_rand[31] ^ r_rand[21] ^ r_rand[1] ^ r_rand[0];
  assign leds        = r_leds;

  always_ff @(posedge clk) begin
    if (memwrite && w_ram_hit) r_ram[w_ram_idx] <= wdata;
    if (w_push) r_fifo[r_wptr] <= key_code;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_timer <= '0;
      r_rand  <= LFSR_SEED;
      r_leds  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);

      // Set wins over a clearing store in the same cycle.
      if (w_drop)                      r_ovf <= 1'b1;
      else if (memwrite && w_stat_hit) r_ovf <= 1'b0;

      if (memwrite && w_timer_hit) r_timer <= wdata;
      else                         r_timer <= r_timer + 32'd1;

      if (memwrite && w_rand_hit) r_rand <= (wdata == '0) ? LFSR_SEED : wdata;
      else                        r_rand <= {r_rand[30:0], w_rand_fb};

      if (memwrite && w_led_hit) r_leds <= wdata[7:0];
    end
  end

  always_comb begin
    rdata = '0;
    if (memread) begin
      if (w_ram_hit)        rdata = r_ram[w_ram_idx];
      else if (w_stat_hit)  rdata = {16'b0, 7'b0, r_ovf, 4'b0, w_cnt_field};
      else if (w_data_hit)  rdata = w_empty ? 32'd0 : {24'b0, r_fifo[r_rptr]};
      else if (w_timer_hit) rdata = r_timer;
      else if (w_rand_hit)  rdata = r_rand;
      else if (w_led_hit)   rdata = {24'b0, r_leds};
    end
  end

endmodule
